// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings, FSM states
// and the shift-op classifier used by the top level.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between issue logic (master) and the sequential ALU
// (slave). Signal names keep the established port names of the block.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic [SHW-1:0]   shamt_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport master (
        output in_valid_i, src1_i, src2_i, ctrl_i, shamt_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, cout_o, overflow_o
    );

    modport slave (
        input  in_valid_i, src1_i, src2_i, ctrl_i, shamt_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, cout_o, overflow_o
    );

endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit logic/arithmetic unit. Shift and unknown codes
// yield zero result and zero flags; shifting is done iteratively by alu_seq.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic             ovf_add;
    logic             ovf_sub;

    assign b_inv   = ~b;
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};

    // Overflow compares against the post-invert operand, so SUB reuses the ADD rule.
    assign ovf_add = (a[MSB] == b[MSB])     && (sum_add[MSB] != a[MSB]);
    assign ovf_sub = (a[MSB] == b_inv[MSB]) && (sum_sub[MSB] != a[MSB]);

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result   = sum_add[WIDTH-1:0];
                cout     = sum_add[WIDTH];
                overflow = ovf_add;
            end
            ALU_SUB: begin
                result   = sum_sub[WIDTH-1:0];
                cout     = sum_sub[WIDTH];
                overflow = ovf_sub;
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum_sub[MSB] ^ ovf_sub};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU: one operation in flight, single-cycle logic and
// arithmetic, shifts performed one bit per cycle in a working register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_seq_if.slave    bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] step;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] core_result;
    logic             core_cout;
    logic             core_ovf;
    logic             multi_cycle;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (bus.src1_i),
        .b        (bus.src2_i),
        .ctrl     (bus.ctrl_i),
        .result   (core_result),
        .cout     (core_cout),
        .overflow (core_ovf)
    );

    assign multi_cycle = is_shift(bus.ctrl_i) && (bus.shamt_i != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: a default assignment first keeps combinational blocks latch-free.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid_i) state_d = multi_cycle ? SHIFT : DONE;
            SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
            DONE:    if (bus.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o  = (state_q == IDLE);
        bus.out_valid_o = (state_q == DONE);
        bus.result_o    = result_q;
        bus.zero_o      = zero_q;
        bus.cout_o      = cout_q;
        bus.overflow_o  = ovf_q;
    end

    // One-bit step of the captured shift; SRA replicates the sign bit.
    always_comb begin
        step = work_q;
        case (op_q)
            ALU_SLL: step = {work_q[WIDTH-2:0], 1'b0};
            ALU_SRL: step = {1'b0, work_q[WIDTH-1:1]};
            ALU_SRA: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: step = work_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: working register and counter reset too, so an aborted shift leaves nothing behind.
            op_q     <= ALU_AND;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid_i) begin
                    op_q <= bus.ctrl_i;
                    if (multi_cycle) begin
                        work_q <= bus.src2_i;
                        cnt_q  <= bus.shamt_i;
                    end else begin
                        if (is_shift(bus.ctrl_i)) begin
                            result_q <= bus.src2_i;
                            zero_q   <= (bus.src2_i == '0);
                        end else begin
                            result_q <= core_result;
                            zero_q   <= (core_result == '0);
                        end
                        cout_q <= core_cout;
                        ovf_q  <= core_ovf;
                    end
                end
                SHIFT: begin
                    work_q <= step;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_q <= step;
                        zero_q   <= (step == '0);
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic op_is_shift(input logic [3:0] op);
        return op == 4'b1000 || op == 4'b1001 || op == 4'b1010;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] n);
        exp_t   e;
        longint u;
        longint s;
        e.r = 32'h0; e.c = 1'b0; e.v = 1'b0;
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b1100: e.r = ~(a | b);
            4'b0010: begin
                u   = longint'(a) + longint'(b);
                s   = longint'($signed(a)) + longint'($signed(b));
                e.r = u[31:0];
                e.c = (u >= 64'sd4294967296);
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                e.r = a - b;
                e.c = (a >= b);
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: e.r = b << n;
            4'b1001: e.r = b >> n;
            4'b1010: e.r = $signed(b) >>> n;
            default: e.r = 32'h0;
        endcase
        e.z = (e.r == 32'h0);
        return e;
    endfunction

    // Waits for in_ready, presents one request for exactly the accept edge,
    // then scrambles the inputs to show they are ignored afterwards.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] n);
        int w = 0;
        while (!bus.in_ready_o && w < 50) begin
            tick();
            w++;
        end
        check("issue_ready", {31'b0, bus.in_ready_o}, 32'd1);
        bus.ctrl_i     = op;
        bus.src1_i     = a;
        bus.src2_i     = b;
        bus.shamt_i    = n;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        bus.src1_i     = $urandom;
        bus.src2_i     = $urandom;
        bus.shamt_i    = 5'($urandom);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int   lat        = 1;
        logic ready_seen = 1'b0;
        while (!bus.out_valid_o && lat < 100) begin
            if (bus.in_ready_o) ready_seen = 1'b1;
            tick();
            lat++;
        end
        if (bus.in_ready_o) ready_seen = 1'b1;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy"}, {31'b0, ready_seen}, 32'd0);
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_result"}, bus.result_o, e.r);
        check({tag, "_zero"}, {31'b0, bus.zero_o}, {31'b0, e.z});
        check({tag, "_cout"}, {31'b0, bus.cout_o}, {31'b0, e.c});
        check({tag, "_ovf"}, {31'b0, bus.overflow_o}, {31'b0, e.v});
    endtask

    task automatic retire(input string tag);
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        check({tag, "_ready_after"}, {31'b0, bus.in_ready_o}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] n);
        exp_t e;
        int   lat;
        e   = model(op, a, b, n);
        lat = (op_is_shift(op) && n != 5'd0) ? 1 + int'(n) : 1;
        issue(op, a, b, n);
        wait_result(tag, lat);
        check_outputs(tag, e);
        retire(tag);
    endtask

    logic [3:0] op_table [10] = '{4'b0000, 4'b0001, 4'b1100, 4'b0010, 4'b0110,
                                  4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1111};

    initial begin
        rst             = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.ctrl_i      = ALU_ADD;
        bus.src1_i      = 32'd1;
        bus.src2_i      = 32'd1;
        bus.shamt_i     = 5'd0;
        bus.out_ready_i = 1'b0;

        // Reset with a request present: it must be dropped.
        tick();
        tick();
        check("rst_out_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("rst_result", bus.result_o, 32'h0);
        check("rst_zero", {31'b0, bus.zero_o}, 32'd0);
        check("rst_cout", {31'b0, bus.cout_o}, 32'd0);
        check("rst_ovf", {31'b0, bus.overflow_o}, 32'd0);
        rst            = 1'b0;
        bus.in_valid_i = 1'b0;
        tick();
        check("rst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
        check("rst_dropped", {31'b0, bus.out_valid_o}, 32'd0);

        run_op("add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        run_op("sub_zero", ALU_SUB, 32'h00000005, 32'h00000005, 5'd0);
        run_op("sub_brw",  ALU_SUB, 32'h00000000, 32'h00000001, 5'd0);
        run_op("slt_neg",  ALU_SLT, 32'h80000000, 32'h00000001, 5'd0);
        run_op("slt_ovf",  ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 5'd0);
        run_op("slt_eq",   ALU_SLT, 32'h00000003, 32'h00000003, 5'd0);
        run_op("sra4",     ALU_SRA, 32'h12345678, 32'hF0000000, 5'd4);
        run_op("srl0",     ALU_SRL, 32'h00000000, 32'hA5A5A5A5, 5'd0);
        run_op("sll31",    ALU_SLL, 32'h00000000, 32'h00000001, 5'd31);
        run_op("nor",      ALU_NOR, 32'h0F0F0000, 32'h000000FF, 5'd0);
        run_op("bad_op",   4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);

        // Backpressure: result held while a new request waits at the input.
        issue(ALU_ADD, 32'd10, 32'd20, 5'd0);
        wait_result("bp_first", 1);
        check_outputs("bp_first", model(ALU_ADD, 32'd10, 32'd20, 5'd0));
        bus.ctrl_i     = ALU_OR;
        bus.src1_i     = 32'h000000F0;
        bus.src2_i     = 32'h00000F00;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", {31'b0, bus.out_valid_o}, 32'd1);
            check("bp_result", bus.result_o, 32'd30);
            check("bp_no_accept", {31'b0, bus.in_ready_o}, 32'd0);
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        check("bp_release_ready", {31'b0, bus.in_ready_o}, 32'd1);
        check("bp_release_valid", {31'b0, bus.out_valid_o}, 32'd0);
        tick();
        bus.in_valid_i = 1'b0;
        wait_result("bp_second", 1);
        check_outputs("bp_second", model(ALU_OR, 32'h000000F0, 32'h00000F00, 5'd0));
        retire("bp_second");

        // Reset on the third SHIFT cycle of a 10-step shift.
        issue(ALU_SRL, 32'h0, 32'hFFFF0000, 5'd10);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("abort_result", bus.result_o, 32'h0);
        check("abort_zero", {31'b0, bus.zero_o}, 32'd0);
        check("abort_cout", {31'b0, bus.cout_o}, 32'd0);
        check("abort_ovf", {31'b0, bus.overflow_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("abort_ready", {31'b0, bus.in_ready_o}, 32'd1);
        run_op("and_after", ALU_AND, 32'h0000F0F0, 32'h0000FF00, 5'd0);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  n;
            op = op_table[$urandom_range(0, 9)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            n  = 5'($urandom_range(0, 31));
            run_op("rand", op, a, b, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
